fetch_stage: RTL

- PC generation and instruction fetch front end; sits directly upstream of the instruction ROM and drives its ce/addr.
- Captures the ROM's combinational instruction word into a small in-order queue and presents {pc, inst} to decode over a valid/ready handshake.
- Handles branch redirect and exception flush.

---
 rtl/fetch_stage_if.sv | 33 +++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Fetch-to-decode handshake bundle. Carries the head entry of
//                the fetch queue ({pc, inst}) with a valid/ready handshake.
//  Signals     : id_valid_o  - head queue entry valid (fetch -> decode)
//                id_pc_o     - PC of head entry      (fetch -> decode)
//                id_inst_o   - instruction of head   (fetch -> decode)
//                id_ready_i  - decode accepts        (decode -> fetch)
//  Modports    : master (fetch side), slave (decode side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;

  modport master (
    output id_valid_o,
    output id_pc_o,
    output id_inst_o,
    input  id_ready_i
  );

  modport slave (
    input  id_valid_o,
    input  id_pc_o,
    input  id_inst_o,
    output id_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : PC generator and instruction fetch front end. Drives the
//                instruction ROM (ce/pc), captures the combinational ROM word
//                into a small in-order queue and presents {pc, inst} to decode
//                over a valid/ready handshake. Handles branch redirect and
//                exception flush (flush has priority over branch).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                ce, pc              - ROM chip enable and fetch address
//                inst_i              - ROM data (combinational from pc)
//                branch_flag_i/_target_i - redirect request and address
//                flush_i, new_pc_i   - exception/ERET flush and target
//                id (master modport) - decode handshake (valid/pc/inst/ready)
//                perf_fetch_o, perf_full_o - only with FETCH_PERF_EN defined
//  Options     : `define FETCH_PERF_EN adds push and queue-full cycle counters
//  Parameters  : RESET_PC (low 2 bits zero), QDEPTH (2 or 4)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ce,
  output logic [31:0]   pc,
  input  logic [31:0]   inst_i,
  input  logic          branch_flag_i,
  input  logic [31:0]   branch_target_i,
  input  logic          flush_i,
  input  logic [31:0]   new_pc_i,
  fetch_stage_if.master id
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_o,
  output logic [31:0]   perf_full_o
`endif
);

  localparam int             PW      = $clog2(QDEPTH);
  localparam int             CW      = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0]  C_DEPTH = CW'(QDEPTH);

  // Registered state
  logic          running_q;
  logic [31:0]   pc_q,    pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q,    rd_d;
  logic [PW-1:0] wr_q,    wr_d;
  logic [31:0]   qpc_q   [QDEPTH];
  logic [31:0]   qinst_q [QDEPTH];

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          push;
  logic          pop;
  logic          valid;

  // ce is derived only from registered state; redirects do not gate it,
  // they only suppress the push of the word fetched in that cycle.
  assign ce       = running_q && (count_q < C_DEPTH);
  assign pc       = pc_q;
  assign redirect = flush_i || branch_flag_i;
  assign push     = ce && !redirect;
  assign valid    = (count_q != '0);
  assign pop      = valid && id.id_ready_i;

  // Flush wins over branch; the low two address bits are forced to zero.
  assign redirect_pc = (flush_i ? new_pc_i : branch_target_i) & 32'hFFFF_FFFC;

  assign id.id_valid_o = valid;
  assign id.id_pc_o    = valid ? qpc_q[rd_q]   : 32'h0;
  assign id.id_inst_o  = valid ? qinst_q[rd_q] : 32'h0;

  // Next-state logic. A redirect discards every queued entry: decode only
  // raises branch_flag_i after it has consumed the delay slot, so nothing
  // still queued belongs to the architectural path.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      pc_q      <= RESET_PC;
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      running_q <= 1'b1;
      pc_q      <= pc_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  // Queue storage needs no reset: entries are only ever presented while
  // count is non-zero, i.e. after they have been written.
  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_q]   <= pc_q;
      qinst_q[wr_q] <= inst_i;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'h0;
      perf_full_q  <= 32'h0;
    end else begin
      if (push) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (running_q && (count_q == C_DEPTH)) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_full_o  = perf_full_q;
`endif

endmodule
`default_nettype wire
